boundary_flit_rx: RTL and testbench
===================================

// Module: boundary_flit_rx
// PURPOSE
//  Receive end of a clock-boundary ring link: captures flits arriving from the
//  clockBoundary register stage, buffers them in a small FIFO, and presents them
//  to the local router through a valid/ready handshake.
//  Returns one credit upstream per drained flit. The upstream clockBoundary/sender
//  may therefore push only while it holds credits.
//  Sits between the boundary register output and the router input port 0.
// PARAMETERS
//  FLIT_W     144  width of a `control_w flit word
//  VALID_BIT  143  bit index of the flit valid flag within the word
//  DEPTH      4    FIFO entries; power of two, >=2; equals upstream initial credits
//  CNT_W      3    width of occupancy; $clog2(DEPTH+1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  port0_ci     in   FLIT_W  flit from boundary stage; accepted when [VALID_BIT]=1
//  flit_co      out  FLIT_W  FIFO head flit; all-zero when empty
//  flit_valid   out  1       head valid (FIFO non-empty)
//  flit_ready   in   1       router accepts head this cycle
//  credit_co    out  1       one-cycle credit-return pulse to upstream
//  occupancy    out  CNT_W   current FIFO fill, 0..DEPTH
//  overflow_err out  1       sticky: a valid flit arrived while full with no pop
// BEHAVIOUR
//  Reset (rst=0, async):
//   - Pointers and occupancy go to 0.
//   - flit_co=0, flit_valid=0, credit_co=0, overflow_err=0.
//   - FIFO storage need not clear.
//   - No credit pulses are emitted after reset; upstream re-initialises to DEPTH.
//  Push:
//   - At posedge, if port0_ci[VALID_BIT]=1, the whole word (valid bit included)
//     is written at wr_ptr; wr_ptr advances mod DEPTH.
//  Pop:
//   - At posedge, if flit_valid && flit_ready, rd_ptr advances mod DEPTH.
//   - flit_ready while empty is ignored.
//  Latency:
//   - A flit pushed at edge N is visible on flit_co/flit_valid after edge N.
//   - No combinational bypass from port0_ci to flit_co.
//  Outputs:
//   - flit_co/flit_valid are driven from storage and occupancy only.
//   - flit_co is forced to zero when occupancy=0.
//  Occupancy update: +1 push only, -1 pop only, unchanged on both or neither.
//  Full (occupancy=DEPTH):
//   - Push with a simultaneous pop is accepted; occupancy stays DEPTH.
//   - Push without a pop is dropped; storage and pointers are unchanged.
//     overflow_err sets and holds until reset.
//  Empty with a simultaneous push:
//   - No pop occurs; occupancy becomes 1.
//  Credit:
//   - credit_co is registered; it is 1 in the cycle after each pop edge, else 0.
//   - Back-to-back pops give back-to-back pulses: exactly one pulse per pop.
//  Pointer wrap: natural mod-DEPTH roll; no full/empty ambiguity, since
//   occupancy is the authority.
//  Reset mid-operation: buffered flits are discarded and pending credit pulses lost;
//   the link restarts from empty.
// TESTING
//  T1 reset:
//   - Hold rst=0 with port0_ci toggling.
//   - All outputs are 0; after release, occupancy=0 and no credit pulse.
//  T2 single flit:
//   - Drive 144'h8000_0123456789abcdef0123456789abcdef for 1 cycle, flit_ready=0.
//   - After that edge: flit_valid=1, flit_co equals that word, occupancy=1.
//   - Then flit_ready=1 for 1 cycle: flit_valid=0, flit_co=0, credit_co=1 for
//     exactly one cycle.
//  T3 invalid word:
//   - Drive 144'h0123456789abcdef0123456789abcdef (valid bit 0) for 3 cycles.
//   - occupancy stays 0 and flit_valid stays 0.
//  T4 fill/overflow:
//   - Push 5 valid flits (payloads 1..5) with flit_ready=0.
//   - occupancy=4, overflow_err=1; drain order is 1,2,3,4; 4 credit pulses.
//  T5 full push+pop:
//   - At occupancy=4, push payload 9 with flit_ready=1.
//   - occupancy stays 4, overflow_err stays 0; payload 9 drains last.
//  T6 streaming:
//   - 20 consecutive valid flits with flit_ready=1 always.
//   - occupancy never exceeds 1; in-order delivery; 20 credit pulses.
//   - No overflow across pointer wraps.

Source files
------------

// File: rtl/boundary_flit_rx_if.sv
// Router-facing handshake of the boundary receiver: head flit, valid and ready.
interface boundary_flit_rx_if #(
  parameter int FLIT_W = 144
);
  logic [FLIT_W-1:0] flit_co;
  logic              flit_valid;
  logic              flit_ready;

  modport master (output flit_co, output flit_valid, input flit_ready);
  modport slave  (input flit_co, input flit_valid, output flit_ready);
endinterface

// File: rtl/boundary_flit_rx.sv
// Receive end of a clock-boundary ring link: a small FIFO that presents flits
// to the router over valid/ready and returns one credit upstream per drained flit.
module boundary_flit_rx #(
  parameter int FLIT_W    = 144,
  parameter int VALID_BIT = 143,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    port0_ci,
  boundary_flit_rx_if.master   rx,
  output logic                 credit_co,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_req;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;

  // Occupancy is the single authority for full/empty, so pointers roll freely.
  always_comb begin
    push_req = port0_ci[VALID_BIT];
    empty    = (occupancy == '0);
    full     = (occupancy == CNT_W'(DEPTH));
    pop      = !empty && rx.flit_ready;
    push     = push_req && (!full || pop);
  end

  assign rx.flit_valid = !empty;
  assign rx.flit_co    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= port0_ci;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      credit_co    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_co <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (push_req && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boundary_flit_rx.sv
// Self-checking bench for boundary_flit_rx: vector table plus queue scoreboard
// and hand-written fill, full push+pop, streaming and reset sequences.
module tb_boundary_flit_rx;

  localparam int FLIT_W = 144;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [FLIT_W-1:0] word;
    logic              ready;
    int                occ;
    logic              valid;
    logic              credit;
    logic [FLIT_W-1:0] flit;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLIT_W-1:0] port0_ci = '0;
  logic              credit_co;
  logic [2:0]        occupancy;
  logic              overflow_err;

  boundary_flit_rx_if #(.FLIT_W(FLIT_W)) rx_if ();

  boundary_flit_rx #(
    .FLIT_W(FLIT_W), .VALID_BIT(143), .DEPTH(DEPTH), .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .port0_ci(port0_ci),
    .rx(rx_if),
    .credit_co(credit_co),
    .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail = 0;
  int                credit_seen = 0;
  int                max_occ = 0;
  logic              exp_ovf = 1'b0;
  logic [FLIT_W-1:0] last_pop = '0;
  logic [FLIT_W-1:0] model_q [$];
  vec_t              vecs [$];

  localparam logic [FLIT_W-1:0] W1 = 144'h8000_0123456789abcdef0123456789abcdef;
  localparam logic [FLIT_W-1:0] W0 = 144'h0123456789abcdef0123456789abcdef;

  function automatic logic [FLIT_W-1:0] mk(input int p);
    return {1'b1, 143'(p)};
  endfunction

  task automatic check_output(input string name, input logic [FLIT_W-1:0] act,
                              input logic [FLIT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update the reference queue, then check after the edge.
  task automatic apply_stimulus(input logic [FLIT_W-1:0] word, input logic ready);
    logic pop;
    logic was_full;
    port0_ci         = word;
    rx_if.flit_ready = ready;
    pop      = (model_q.size() != 0) && ready;
    was_full = (model_q.size() == DEPTH);
    if (pop) begin
      check_output("pop_head", rx_if.flit_co, model_q[0]);
      last_pop = model_q.pop_front();
    end
    if (word[143]) begin
      if (!was_full || pop) model_q.push_back(word);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_output("occupancy", FLIT_W'(occupancy), FLIT_W'(model_q.size()));
    check_output("flit_valid", FLIT_W'(rx_if.flit_valid), FLIT_W'(model_q.size() != 0));
    check_output("flit_co", rx_if.flit_co, (model_q.size() != 0) ? model_q[0] : '0);
    check_output("credit_co", FLIT_W'(credit_co), FLIT_W'(pop));
    check_output("overflow_err", FLIT_W'(overflow_err), FLIT_W'(exp_ovf));
    if (credit_co) credit_seen++;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_flit_co"}, rx_if.flit_co, '0);
    check_output({tag, "_valid"}, FLIT_W'(rx_if.flit_valid), '0);
    check_output({tag, "_occ"}, FLIT_W'(occupancy), '0);
    check_output({tag, "_credit"}, FLIT_W'(credit_co), '0);
    check_output({tag, "_ovf"}, FLIT_W'(overflow_err), '0);
  endtask

  // Reset asserted mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    port0_ci         = mk(77);
    rx_if.flit_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("hold_rst");
    rst = 1'b1;
    model_q.delete();
    exp_ovf = 1'b0;
    apply_stimulus('0, 1'b0);
  endtask

  initial begin
    rx_if.flit_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      port0_ci = (i % 2 == 0) ? mk(i + 1) : W0;
      check_all_zero("t1_rst");
    end
    rst = 1'b1;
    apply_stimulus('0, 1'b0);
    apply_stimulus('0, 1'b0);

    vecs.push_back('{word: W1, ready: 1'b0, occ: 1, valid: 1'b1, credit: 1'b0, flit: W1});
    vecs.push_back('{word: '0, ready: 1'b1, occ: 0, valid: 1'b0, credit: 1'b1, flit: '0});
    vecs.push_back('{word: '0, ready: 1'b0, occ: 0, valid: 1'b0, credit: 1'b0, flit: '0});
    vecs.push_back('{word: W0, ready: 1'b0, occ: 0, valid: 1'b0, credit: 1'b0, flit: '0});
    vecs.push_back('{word: W0, ready: 1'b0, occ: 0, valid: 1'b0, credit: 1'b0, flit: '0});
    vecs.push_back('{word: W0, ready: 1'b0, occ: 0, valid: 1'b0, credit: 1'b0, flit: '0});
    vecs.push_back('{word: '0, ready: 1'b1, occ: 0, valid: 1'b0, credit: 1'b0, flit: '0});
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].word, vecs[i].ready);
      check_output("vec_occ", FLIT_W'(occupancy), FLIT_W'(vecs[i].occ));
      check_output("vec_valid", FLIT_W'(rx_if.flit_valid), FLIT_W'(vecs[i].valid));
      check_output("vec_credit", FLIT_W'(credit_co), FLIT_W'(vecs[i].credit));
      check_output("vec_flit", rx_if.flit_co, vecs[i].flit);
    end

    credit_seen = 0;
    for (int p = 1; p <= 5; p++) apply_stimulus(mk(p), 1'b0);
    check_output("t4_occ_full", FLIT_W'(occupancy), FLIT_W'(4));
    check_output("t4_ovf", FLIT_W'(overflow_err), FLIT_W'(1));
    for (int p = 1; p <= 4; p++) begin
      apply_stimulus('0, 1'b1);
      check_output("t4_drain_order", last_pop, mk(p));
    end
    apply_stimulus('0, 1'b0);
    check_output("t4_credits", FLIT_W'(credit_seen), FLIT_W'(4));
    check_output("t4_ovf_sticky", FLIT_W'(overflow_err), FLIT_W'(1));

    apply_stimulus(mk(33), 1'b0);
    apply_stimulus(mk(34), 1'b0);
    do_reset();

    for (int p = 1; p <= 4; p++) apply_stimulus(mk(p), 1'b0);
    apply_stimulus(mk(9), 1'b1);
    check_output("t5_occ", FLIT_W'(occupancy), FLIT_W'(4));
    check_output("t5_ovf", FLIT_W'(overflow_err), FLIT_W'(0));
    for (int p = 0; p < 4; p++) apply_stimulus('0, 1'b1);
    check_output("t5_last", last_pop, mk(9));
    apply_stimulus('0, 1'b0);

    credit_seen = 0;
    max_occ     = 0;
    for (int i = 0; i < 20; i++) apply_stimulus(mk(100 + i), 1'b1);
    apply_stimulus('0, 1'b1);
    check_output("t6_last", last_pop, mk(119));
    apply_stimulus('0, 1'b0);
    check_output("t6_credits", FLIT_W'(credit_seen), FLIT_W'(20));
    check_output("t6_max_occ_le1", FLIT_W'(max_occ <= 1), FLIT_W'(1));
    check_output("t6_ovf", FLIT_W'(overflow_err), FLIT_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
